// File: rtl/cmd_byte_assembler.sv
// rtl/cmd_byte_assembler.sv - pairs host bytes into 16-bit commands with inter-byte timeout
//
// Purpose: assemble two bytes from the receive FIFO into one 16-bit command,
//   strobe it for one cycle, and drop an orphaned first byte after a timeout.
// Optional feature macro: CMD_ERR_CNT_EN (adds the Err_Cnt timeout counter).
// Ports:
//   Clk_In         system clock
//   Rst_N          asynchronous active-low reset
//   In_Data[8:1]   byte from the receive FIFO
//   In_Valid       In_Data is valid
//   In_Ready       byte accepted this cycle when In_Valid is also high
//   Cmd_Out[16:1]  last assembled command, held between strobes
//   Cmd_En         one-cycle strobe, Cmd_Out is new
//   Busy           state is not IDLE
//   Timeout_Pulse  one-cycle pulse when a first byte is discarded
//   Cmd_Count      commands emitted, wrapping
//   Err_Cnt[7:0]   saturating timeout count (CMD_ERR_CNT_EN only)

module cmd_byte_assembler #(
  parameter logic        MSB_FIRST      = 1'b1,
  parameter logic [15:0] TIMEOUT_CYCLES = 16'd1000,
  parameter int          CNT_WIDTH      = 16
) (
  input  logic                 Clk_In,
  input  logic                 Rst_N,
  input  logic [8:1]           In_Data,
  input  logic                 In_Valid,
  output logic                 In_Ready,
  output logic [16:1]          Cmd_Out,
  output logic                 Cmd_En,
  output logic                 Busy,
  output logic                 Timeout_Pulse,
  output logic [CNT_WIDTH-1:0] Cmd_Count
`ifdef CMD_ERR_CNT_EN
  ,
  output logic [7:0]           Err_Cnt
`endif
);

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_WAIT_2ND = 2'd1,
    S_EMIT     = 2'd2
  } state_t;

  state_t               r_state;
  state_t               w_next_state;
  logic [8:1]           r_first;
  logic [15:0]          r_timer;
  logic [16:1]          r_cmd;
  logic                 r_cmd_en;
  logic                 r_timeout_pulse;
  logic [CNT_WIDTH-1:0] r_cmd_count;

  logic                 w_ready;
  logic                 w_accept;
  logic                 w_timeout;
  logic [16:1]          w_cmd;

  assign w_ready  = (r_state != S_EMIT);
  assign w_accept = In_Valid && w_ready;
  assign w_cmd    = MSB_FIRST ? {r_first, In_Data} : {In_Data, r_first};

  // An accept on the expiry cycle wins, so expiry is qualified by !w_accept.
  assign w_timeout = (r_state == S_WAIT_2ND) && !w_accept &&
                     (TIMEOUT_CYCLES != 16'd0) &&
                     (r_timer == TIMEOUT_CYCLES - 16'd1);

  always_ff @(posedge Clk_In or negedge Rst_N) begin
    if (!Rst_N) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_accept) w_next_state = S_WAIT_2ND;
      end
      S_WAIT_2ND: begin
        if (w_accept)       w_next_state = S_EMIT;
        else if (w_timeout) w_next_state = S_IDLE;
      end
      S_EMIT: begin
        w_next_state = S_IDLE;
      end
      default: begin
        w_next_state = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge Clk_In or negedge Rst_N) begin
    if (!Rst_N) begin
      r_first         <= 8'h00;
      r_timer         <= 16'd0;
      r_cmd           <= 16'h0000;
      r_cmd_en        <= 1'b0;
      r_timeout_pulse <= 1'b0;
      r_cmd_count     <= '0;
    end else begin
      r_cmd_en        <= 1'b0;
      r_timeout_pulse <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_first <= In_Data;
            r_timer <= 16'd0;
          end
        end
        S_WAIT_2ND: begin
          if (w_accept) begin
            r_cmd       <= w_cmd;
            r_cmd_en    <= 1'b1;
            r_cmd_count <= r_cmd_count + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
          end else if (w_timeout) begin
            r_timeout_pulse <= 1'b1;
            r_timer         <= 16'd0;
          end else begin
            r_timer <= r_timer + 16'd1;
          end
        end
        default: begin
        end
      endcase
    end
  end

`ifdef CMD_ERR_CNT_EN
  logic [7:0] r_err_cnt;

  // An all-ones command doubles as the host's "clear error count" request.
  always_ff @(posedge Clk_In or negedge Rst_N) begin
    if (!Rst_N) begin
      r_err_cnt <= 8'h00;
    end else if ((r_state == S_WAIT_2ND) && w_accept && (w_cmd == 16'hFFFF)) begin
      r_err_cnt <= 8'h00;
    end else if (w_timeout && (r_err_cnt != 8'hFF)) begin
      r_err_cnt <= r_err_cnt + 8'd1;
    end
  end

  assign Err_Cnt = r_err_cnt;
`endif

  assign In_Ready      = w_ready;
  assign Cmd_Out       = r_cmd;
  assign Cmd_En        = r_cmd_en;
  assign Busy          = (r_state != S_IDLE);
  assign Timeout_Pulse = r_timeout_pulse;
  assign Cmd_Count     = r_cmd_count;

endmodule
